keypad_digit_receiver: RTL

Receiving end of the keypad encoder interface. Samples the encoder's 4-bit BCD code `d` and active-low load strobe `loadn` into the microwave clock domain. On each new key press it shifts the digit into a 4-digit MM:SS entry register. The entry register feeds the cook-time loader and the display decoder.

---
 rtl/microwave_pkg.sv | 18 +
 rtl/keypad_digit_receiver_sync_edge_detect.sv | 35 +++
 rtl/keypad_digit_receiver.sv | 92 +++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave controller keypad/entry path.
package microwave_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned BCD_MAX      = 9;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned NUM_DIGITS   = 4;
    localparam int unsigned CNT_W        = 3;

    // Position of each digit in the packed entry register (index 0 = newest).
    localparam int unsigned IDX_SEC_ONES = 0;
    localparam int unsigned IDX_SEC_TENS = 1;
    localparam int unsigned IDX_MIN_ONES = 2;
    localparam int unsigned IDX_MIN_TENS = 3;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] entry_t;

endpackage

// File: rtl/keypad_digit_receiver_sync_edge_detect.sv
// Synchronizes the encoder strobe and code together and flags falling edges
// of the synchronized strobe.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned W           = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         loadn,
    input  logic [W-1:0] d,
    output logic         press_c,
    output logic [W-1:0] d_sync
);

    logic [SYNC_STAGES-1:0]        loadn_pipe;
    logic [SYNC_STAGES-1:0][W-1:0] d_pipe;
    logic                          loadn_prev;

    // Strobe and code travel through identical stage counts so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadn_pipe <= '1;
            d_pipe     <= '0;
            loadn_prev <= 1'b1;
        end else begin
            loadn_pipe <= {loadn_pipe[SYNC_STAGES-2:0], loadn};
            d_pipe     <= {d_pipe[SYNC_STAGES-2:0], d};
            loadn_prev <= loadn_pipe[SYNC_STAGES-1];
        end
    end

    assign press_c = ~loadn_pipe[SYNC_STAGES-1] & loadn_prev;
    assign d_sync  = d_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_digit_receiver.sv
// Keypad receiver: shifts each new BCD key press into a 4-digit MM:SS entry.
module keypad_digit_receiver
    import microwave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] d,
    input  logic               loadn,
    input  logic               clear,
    input  logic               lock,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [CNT_W-1:0]   digit_cnt,
    output logic               time_valid,
    output logic               digit_stb,
    output logic               err_stb
);

    logic               press_c;
    logic [DIGIT_W-1:0] d_sync;

    entry_t             entry_q, entry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               digit_stb_q, digit_stb_d;
    logic               err_stb_q, err_stb_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (DIGIT_W)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .loadn   (loadn),
        .d       (d),
        .press_c (press_c),
        .d_sync  (d_sync)
    );

    // Clear outranks lock and any press; locked presses are dropped silently.
    always_comb begin
        entry_d     = entry_q;
        cnt_d       = cnt_q;
        digit_stb_d = 1'b0;
        err_stb_d   = 1'b0;
        if (clear) begin
            entry_d = '0;
            cnt_d   = '0;
        end else if (press_c && !lock) begin
            if (d_sync <= DIGIT_W'(BCD_MAX)) begin
                entry_d     = {entry_q[NUM_DIGITS-2:0], d_sync};
                digit_stb_d = 1'b1;
                if (cnt_q != CNT_W'(NUM_DIGITS)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                err_stb_d = 1'b1;
            end
        end
        valid_d = (entry_d != '0) && (entry_d[IDX_SEC_TENS] <= DIGIT_W'(SEC_TENS_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q     <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            digit_stb_q <= 1'b0;
            err_stb_q   <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            digit_stb_q <= digit_stb_d;
            err_stb_q   <= err_stb_d;
        end
    end

    assign min_tens   = entry_q[IDX_MIN_TENS];
    assign min_ones   = entry_q[IDX_MIN_ONES];
    assign sec_tens   = entry_q[IDX_SEC_TENS];
    assign sec_ones   = entry_q[IDX_SEC_ONES];
    assign digit_cnt  = cnt_q;
    assign time_valid = valid_q;
    assign digit_stb  = digit_stb_q;
    assign err_stb    = err_stb_q;

endmodule
